// File: rtl/snake_pkg.sv
// Shared snake-game types and constants: direction codes, empty-segment marker, FSM
// encoding and default playfield geometry.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [31:0] SEG_NONE = 32'hFFFF_FFFF;

  localparam int unsigned DEF_MAX_LEN   = 100;
  localparam int unsigned DEF_GRID_W    = 10;
  localparam int unsigned DEF_GRID_H    = 10;
  localparam int unsigned DEF_START_X   = 4;
  localparam int unsigned DEF_START_Y   = 4;
  localparam int unsigned DEF_START_LEN = 3;

  // Width of the length/score-index domain; MAX_LEN must fit.
  localparam int unsigned LEN_W = 8;

  typedef enum logic [1:0] {
    StRun,
    StScan,
    StCommit,
    StDead
  } state_e;

  // Opposite directions differ only in the top bit of the encoding.
  function automatic logic [1:0] dir_opposite(input logic [1:0] dir);
    return dir ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_collision_scan.sv
// Serial self-collision comparator: walks segment indices 0..limit-1, one per cycle,
// reporting a hit on the first segment equal to the target tile, or done at the limit.
module snake_collision_scan
  import snake_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic [LEN_W-1:0] limit,
  input  logic [7:0]       target_x,
  input  logic [7:0]       target_y,
  input  logic [7:0]       seg_x,
  input  logic [7:0]       seg_y,
  output logic [LEN_W-1:0] idx,
  output logic             hit,
  output logic             done
);

  logic             active_q, active_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] limit_q, limit_d;
  logic             in_range;
  logic             last;

  always_comb begin
    in_range = idx_q < limit_q;
    // Extra bit so the compare stays correct at the top of the index range.
    last     = ((LEN_W + 1)'(idx_q) + (LEN_W + 1)'(1)) >= (LEN_W + 1)'(limit_q);
    hit      = active_q && in_range && (seg_x == target_x) && (seg_y == target_y);
    done     = active_q && !hit && last;

    active_d = active_q;
    idx_d    = idx_q;
    limit_d  = limit_q;
    if (clear) begin
      active_d = 1'b0;
    end else if (start) begin
      active_d = 1'b1;
      idx_d    = '0;
      limit_d  = limit;
    end else if (active_q) begin
      if (hit || done) begin
        active_d = 1'b0;
      end else begin
        idx_d = idx_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= 1'b0;
      idx_q    <= '0;
      limit_q  <= '0;
    end else begin
      active_q <= active_d;
      idx_q    <= idx_d;
      limit_q  <= limit_d;
    end
  end

  assign idx = idx_q;

endmodule

// File: rtl/snake_body_engine.sv
// Snake body state machine: per game tick advances the head, checks walls and self-collision,
// eats food, and publishes the body in a single commit cycle.
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN   = DEF_MAX_LEN,
  parameter int unsigned GRID_W    = DEF_GRID_W,
  parameter int unsigned GRID_H    = DEF_GRID_H,
  parameter int unsigned START_X   = DEF_START_X,
  parameter int unsigned START_Y   = DEF_START_Y,
  parameter int unsigned START_LEN = DEF_START_LEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step,
  input  logic [1:0]            dir_in,
  input  logic                  restart,
  input  logic [31:0]           food_x,
  input  logic [31:0]           food_y,
  output logic [32*MAX_LEN-1:0] x_values,
  output logic [32*MAX_LEN-1:0] y_values,
  output logic [7:0]            length,
  output logic [31:0]           score,
  output logic                  ate,
  output logic                  busy,
  output logic                  game_done
);

  localparam int unsigned      IdxW     = $clog2(MAX_LEN);
  localparam logic [7:0]       XMax     = 8'(GRID_W - 1);
  localparam logic [7:0]       YMax     = 8'(GRID_H - 1);
  localparam logic [LEN_W-1:0] MaxLen   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] StartLen = LEN_W'(START_LEN);

  state_e           state_q, state_d;
  logic [7:0]       body_x_q [MAX_LEN];
  logic [7:0]       body_x_d [MAX_LEN];
  logic [7:0]       body_y_q [MAX_LEN];
  logic [7:0]       body_y_d [MAX_LEN];
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      score_q, score_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       new_dir_q, new_dir_d;
  logic [7:0]       nxt_x_q, nxt_x_d;
  logic [7:0]       nxt_y_q, nxt_y_d;
  logic             eat_q, eat_d;

  logic [1:0]       chosen_dir;
  logic [7:0]       head_x, head_y;
  logic [7:0]       cand_x, cand_y;
  logic             wall;
  logic             cand_eat;
  logic             scan_start;
  logic             scan_hit;
  logic             scan_done;
  logic [LEN_W-1:0] scan_limit;
  logic [LEN_W-1:0] scan_idx;
  logic [7:0]       seg_x, seg_y;
  logic             unused_bits;

  function automatic logic [7:0] start_x(input int i);
    return (i < int'(START_LEN)) ? 8'(int'(START_X) - i) : 8'hFF;
  endfunction

  function automatic logic [7:0] start_y(input int i);
    return (i < int'(START_LEN)) ? 8'(START_Y) : 8'hFF;
  endfunction

  // Only the low coordinate byte is meaningful.
  assign unused_bits = ^{food_x[31:8], food_y[31:8], scan_idx[LEN_W-1:IdxW]};

  always_comb begin
    head_x     = body_x_q[0];
    head_y     = body_y_q[0];
    chosen_dir = (dir_in == dir_opposite(dir_q)) ? dir_q : dir_in;
    cand_x     = head_x;
    cand_y     = head_y;
    wall       = 1'b0;
    // Wall test precedes the arithmetic, so a wrapped candidate is never used.
    case (chosen_dir)
      DIR_UP: begin
        wall   = (head_y == 8'd0);
        cand_y = head_y - 8'd1;
      end
      DIR_RIGHT: begin
        wall   = (head_x == XMax);
        cand_x = head_x + 8'd1;
      end
      DIR_DOWN: begin
        wall   = (head_y == YMax);
        cand_y = head_y + 8'd1;
      end
      default: begin
        wall   = (head_x == 8'd0);
        cand_x = head_x - 8'd1;
      end
    endcase
    cand_eat   = (cand_x == food_x[7:0]) && (cand_y == food_y[7:0]);
    // Without food the tail vacates its tile, so it is excluded from the scan.
    scan_limit = cand_eat ? len_q : len_q - LEN_W'(1);
    scan_start = (state_q == StRun) && step && !restart && !wall;
    seg_x      = body_x_q[scan_idx[IdxW-1:0]];
    seg_y      = body_y_q[scan_idx[IdxW-1:0]];
  end

  snake_collision_scan u_scan (
    .clk      (clk),
    .reset    (reset),
    .clear    (restart),
    .start    (scan_start),
    .limit    (scan_limit),
    .target_x (nxt_x_q),
    .target_y (nxt_y_q),
    .seg_x    (seg_x),
    .seg_y    (seg_y),
    .idx      (scan_idx),
    .hit      (scan_hit),
    .done     (scan_done)
  );

  always_comb begin
    state_d   = state_q;
    body_x_d  = body_x_q;
    body_y_d  = body_y_q;
    len_d     = len_q;
    score_d   = score_q;
    dir_d     = dir_q;
    new_dir_d = new_dir_q;
    nxt_x_d   = nxt_x_q;
    nxt_y_d   = nxt_y_q;
    eat_d     = eat_q;

    if (restart) begin
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        body_x_d[i] = start_x(i);
        body_y_d[i] = start_y(i);
      end
      len_d   = StartLen;
      score_d = '0;
      dir_d   = DIR_RIGHT;
      eat_d   = 1'b0;
      state_d = StRun;
    end else begin
      case (state_q)
        StRun: begin
          if (step) begin
            if (wall) begin
              state_d = StDead;
            end else begin
              nxt_x_d   = cand_x;
              nxt_y_d   = cand_y;
              eat_d     = cand_eat;
              new_dir_d = chosen_dir;
              state_d   = StScan;
            end
          end
        end
        StScan: begin
          if (scan_hit) begin
            state_d = StDead;
          end else if (scan_done) begin
            state_d = StCommit;
          end
        end
        StCommit: begin
          for (int i = 1; i < int'(MAX_LEN); i++) begin
            body_x_d[i] = body_x_q[i-1];
            body_y_d[i] = body_y_q[i-1];
          end
          body_x_d[0] = nxt_x_q;
          body_y_d[0] = nxt_y_q;
          // Slots at or beyond len are published as empty, so a dropped tail needs no write.
          if (eat_q) begin
            score_d = score_q + 32'd1;
            if (len_q < MaxLen) begin
              len_d = len_q + LEN_W'(1);
            end
          end
          dir_d   = new_dir_q;
          state_d = StRun;
        end
        StDead: begin
          state_d = StDead;
        end
        default: begin
          state_d = StRun;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        body_x_q[i] <= start_x(i);
        body_y_q[i] <= start_y(i);
      end
      state_q   <= StRun;
      len_q     <= StartLen;
      score_q   <= '0;
      dir_q     <= DIR_RIGHT;
      new_dir_q <= DIR_RIGHT;
      nxt_x_q   <= '0;
      nxt_y_q   <= '0;
      eat_q     <= 1'b0;
    end else begin
      body_x_q  <= body_x_d;
      body_y_q  <= body_y_d;
      state_q   <= state_d;
      len_q     <= len_d;
      score_q   <= score_d;
      dir_q     <= dir_d;
      new_dir_q <= new_dir_d;
      nxt_x_q   <= nxt_x_d;
      nxt_y_q   <= nxt_y_d;
      eat_q     <= eat_d;
    end
  end

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_publish
    assign x_values[32*g +: 32] = (LEN_W'(g) < len_q) ? {24'd0, body_x_q[g]} : SEG_NONE;
    assign y_values[32*g +: 32] = (LEN_W'(g) < len_q) ? {24'd0, body_y_q[g]} : SEG_NONE;
  end

  assign length    = len_q;
  assign score     = score_q;
  assign ate       = (state_q == StCommit) && eat_q;
  assign busy      = (state_q == StScan) || (state_q == StCommit);
  assign game_done = (state_q == StDead);

endmodule

// File: tb/tb_snake_body_engine.sv
// Scoreboard bench for snake_body_engine: directed moves push expected body snapshots,
// a negedge monitor compares them whenever a move settles or a probe is queued.
module tb_snake_body_engine;
  import snake_pkg::*;

  localparam int unsigned ML = 100;
  localparam logic [31:0] N = SEG_NONE;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            step = 1'b0;
  logic [1:0]      dir_in = DIR_RIGHT;
  logic            restart = 1'b0;
  logic [31:0]     food_x = 32'd9;
  logic [31:0]     food_y = 32'd9;
  logic [32*ML-1:0] x_values;
  logic [32*ML-1:0] y_values;
  logic [7:0]      length;
  logic [31:0]     score;
  logic            ate;
  logic            busy;
  logic            game_done;

  always #5 clk = ~clk;

  snake_body_engine dut (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .dir_in    (dir_in),
    .restart   (restart),
    .food_x    (food_x),
    .food_y    (food_y),
    .x_values  (x_values),
    .y_values  (y_values),
    .length    (length),
    .score     (score),
    .ate       (ate),
    .busy      (busy),
    .game_done (game_done)
  );

  typedef logic [31:0] slots_t [6];
  typedef struct {
    string  name;
    bit     probe;
    int     busy_cyc;
    int     ate_cnt;
    int     len;
    int     score;
    bit     done;
    slots_t xs;
    slots_t ys;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   busy_cnt = 0;
  int   ate_seen = 0;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input string what, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s.%s: got %0h, expected %0h", name, what, got, want);
    end
  endtask

  task automatic compare(input exp_t e);
    for (int i = 0; i < 6; i++) begin
      check(e.name, $sformatf("x%0d", i), x_values[32*i +: 32], e.xs[i]);
      check(e.name, $sformatf("y%0d", i), y_values[32*i +: 32], e.ys[i]);
    end
    check(e.name, "length", 32'(length), 32'(e.len));
    check(e.name, "score", score, 32'(e.score));
    check(e.name, "game_done", 32'(game_done), 32'(e.done));
    check(e.name, "ate_pulses", 32'(ate_seen), 32'(e.ate_cnt));
    if (e.busy_cyc >= 0) check(e.name, "busy_cycles", 32'(busy_cnt), 32'(e.busy_cyc));
  endtask

  // Monitor: a move settles when busy falls, or when a wall death raises game_done.
  always @(negedge clk) begin
    exp_t e;
    bit   settle;
    if (busy) busy_cnt++;
    if (ate) ate_seen++;
    settle = (prev_busy && !busy) || (!prev_done && game_done && !prev_busy);
    if (q.size() > 0 && q[0].probe) begin
      e = q.pop_front();
      compare(e);
      busy_cnt = 0;
      ate_seen = 0;
    end else if (settle) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        compare(e);
      end else begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: DUT settled a move, none was expected");
      end
      busy_cnt = 0;
      ate_seen = 0;
    end
    prev_busy = busy;
    prev_done = game_done;
  end

  task automatic expect_state(input string name, input bit probe, input int busy_cyc,
                              input int atec, input int len, input int sc, input bit done,
                              input slots_t xs, input slots_t ys);
    exp_t e;
    e.name = name; e.probe = probe; e.busy_cyc = busy_cyc; e.ate_cnt = atec;
    e.len = len; e.score = sc; e.done = done; e.xs = xs; e.ys = ys;
    q.push_back(e);
  endtask

  task automatic do_step(input logic [1:0] d, input int fx, input int fy);
    @(negedge clk);
    dir_in = d;
    food_x = 32'(fx);
    food_y = 32'(fy);
    step   = 1'b1;
    @(negedge clk);
    step   = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s.timeout: %0d expectations pending, expected 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin
    slots_t xs, ys;
    slots_t t1x, t1y;
    t1x = '{4, 3, 2, N, N, N};
    t1y = '{4, 4, 4, N, N, N};

    repeat (3) @(negedge clk);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;
    expect_state("t1_reset", 1, -1, 0, 3, 0, 0, t1x, t1y);
    drain("t1_reset");

    xs = '{5, 4, 3, N, N, N}; ys = '{4, 4, 4, N, N, N};
    expect_state("t2_move", 0, 3, 0, 3, 0, 0, xs, ys);
    do_step(DIR_RIGHT, 9, 9);
    drain("t2_move");

    xs = '{6, 5, 4, 3, N, N}; ys = '{4, 4, 4, 4, N, N};
    expect_state("t3_eat", 0, 4, 1, 4, 1, 0, xs, ys);
    do_step(DIR_RIGHT, 6, 4);
    drain("t3_eat");

    xs = '{7, 6, 5, 4, N, N};
    expect_state("t4_reverse", 0, 4, 0, 4, 1, 0, xs, ys);
    do_step(DIR_LEFT, 9, 9);
    drain("t4_reverse");

    xs = '{8, 7, 6, 5, N, N};
    expect_state("t4_x8", 0, 4, 0, 4, 1, 0, xs, ys);
    do_step(DIR_RIGHT, 0, 0);
    drain("t4_x8");

    xs = '{9, 8, 7, 6, N, N};
    expect_state("t4_x9", 0, 4, 0, 4, 1, 0, xs, ys);
    do_step(DIR_RIGHT, 0, 0);
    drain("t4_x9");

    expect_state("t4_wall", 0, 0, 0, 4, 1, 1, xs, ys);
    do_step(DIR_RIGHT, 0, 0);
    drain("t4_wall");

    do_step(DIR_UP, 0, 0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    expect_state("t6_dead_step", 1, -1, 0, 4, 1, 1, xs, ys);
    drain("t6_dead_step");

    do_restart();
    @(posedge clk); #1;
    expect_state("t6_restart", 1, -1, 0, 3, 0, 0, t1x, t1y);
    drain("t6_restart");

    xs = '{5, 4, 3, 2, N, N}; ys = '{4, 4, 4, 4, N, N};
    expect_state("t5_eat1", 0, 4, 1, 4, 1, 0, xs, ys);
    do_step(DIR_RIGHT, 5, 4);
    drain("t5_eat1");

    xs = '{6, 5, 4, 3, 2, N}; ys = '{4, 4, 4, 4, 4, N};
    expect_state("t5_eat2", 0, 5, 1, 5, 2, 0, xs, ys);
    do_step(DIR_RIGHT, 6, 4);
    drain("t5_eat2");

    xs = '{6, 6, 5, 4, 3, N}; ys = '{3, 4, 4, 4, 4, N};
    expect_state("t5_up", 0, 5, 0, 5, 2, 0, xs, ys);
    do_step(DIR_UP, 0, 0);
    drain("t5_up");

    xs = '{5, 6, 6, 5, 4, N}; ys = '{3, 3, 4, 4, 4, N};
    expect_state("t5_left", 0, 5, 0, 5, 2, 0, xs, ys);
    do_step(DIR_LEFT, 0, 0);
    drain("t5_left");

    expect_state("t5_bite", 0, 4, 0, 5, 2, 1, xs, ys);
    do_step(DIR_DOWN, 0, 0);
    drain("t5_bite");

    do_restart();
    // Restart together with a step: restart must win and no move may follow.
    @(negedge clk);
    restart = 1'b1; step = 1'b1; dir_in = DIR_UP;
    @(negedge clk);
    restart = 1'b0; step = 1'b0;
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
    expect_state("restart_wins", 1, -1, 0, 3, 0, 0, t1x, t1y);
    drain("restart_wins");

    xs = '{5, 4, 3, 2, N, N}; ys = '{4, 4, 4, 4, N, N};
    expect_state("tc_eat", 0, 4, 1, 4, 1, 0, xs, ys);
    do_step(DIR_RIGHT, 5, 4);
    drain("tc_eat");

    xs = '{5, 5, 4, 3, N, N}; ys = '{3, 4, 4, 4, N, N};
    expect_state("tc_up", 0, 4, 0, 4, 1, 0, xs, ys);
    do_step(DIR_UP, 0, 0);
    drain("tc_up");

    xs = '{4, 5, 5, 4, N, N}; ys = '{3, 3, 4, 4, N, N};
    expect_state("tc_left", 0, 4, 0, 4, 1, 0, xs, ys);
    do_step(DIR_LEFT, 0, 0);
    drain("tc_left");

    xs = '{4, 4, 5, 5, N, N}; ys = '{4, 3, 3, 4, N, N};
    expect_state("tc_chase_tail", 0, 4, 0, 4, 1, 0, xs, ys);
    do_step(DIR_DOWN, 0, 0);
    drain("tc_chase_tail");

    do_restart();
    // Step held for three edges: only the first, taken in RUN, may move the snake.
    xs = '{5, 4, 3, N, N, N}; ys = '{4, 4, 4, N, N, N};
    expect_state("t6_one_move", 0, 3, 0, 3, 0, 0, xs, ys);
    @(negedge clk);
    dir_in = DIR_RIGHT; food_x = 32'd9; food_y = 32'd9; step = 1'b1;
    repeat (3) @(negedge clk);
    step = 1'b0;
    drain("t6_one_move");
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    expect_state("t6_no_second", 1, -1, 0, 3, 0, 0, xs, ys);
    drain("t6_no_second");

    do_step(DIR_RIGHT, 9, 9);
    @(posedge clk); #2 reset = 1'b0;
    expect_state("t6_reset_scan", 1, -1, 0, 3, 0, 0, t1x, t1y);
    drain("t6_reset_scan");
    @(posedge clk); #2 reset = 1'b1;

    xs = '{5, 4, 3, N, N, N}; ys = '{4, 4, 4, N, N, N};
    expect_state("post_reset_move", 0, 3, 0, 3, 0, 0, xs, ys);
    do_step(DIR_RIGHT, 9, 9);
    drain("post_reset_move");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks,
             failures);
    $fatal(1, "watchdog");
  end

endmodule
